// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, execute redirect and decode-side queue head.
// master = fetch unit, slave = surrounding pipeline / memory.
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        misalign_err;

  modport master (
    output imem_addr,
    input  imem_instruction,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc,
    output misalign_err
  );

  modport slave (
    input  imem_addr,
    output imem_instruction,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc,
    input  misalign_err
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC owner plus a DEPTH-entry {pc, instruction} queue toward decode.
// Optional FETCH_ALIGN_CHECK_EN: force-align redirect targets and flag misaligned ones.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_unit_if.master bus
);
  localparam int unsigned   PtrW      = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0] CountOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [31:0]     pc_q, pc_d;
  logic [PtrW:0]   count_q, count_d;
  logic [PtrW-1:0] rd_q, wr_q;
  logic [31:0]     q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic            flush, push, pop;
  logic [31:0]     redirect_target;

  assign flush = bus.redirect_valid;
  assign pop   = (count_q != '0) & bus.out_ready & ~flush;
  // A full queue still accepts a new entry when the head leaves in the same cycle.
  assign push  = ~flush & ((count_q != CountFull) | pop);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= flush & (bus.redirect_pc[1:0] != 2'b00);
    end
  end

  assign bus.misalign_err = misalign_q;
`else
  assign redirect_target  = bus.redirect_pc;
  assign bus.misalign_err = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (flush) begin
      pc_d    = redirect_target;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      if (flush) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PtrOne;
        if (pop)  rd_q <= rd_q + PtrOne;
      end
    end
  end

  // Payload storage needs no reset: entries are only observed once counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_q]    <= pc_q;
      q_instr[wr_q] <= bus.imem_instruction;
    end
  end

  assign bus.imem_addr       = pc_q;
  assign bus.out_valid       = (count_q != '0);
  assign bus.out_pc          = q_pc[rd_q];
  assign bus.out_instruction = q_instr[rd_q];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: queue-level reference model checked every
// cycle, plus directed sequences with literal expected PCs.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam int unsigned DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_VECTOR(RV),
    .DEPTH       (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign bus.imem_instruction = mem_word(bus.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, instr} entries and the next fetch address.
  logic [63:0] mq[$];
  logic [31:0] m_pc  = RV;
  logic        m_mis = 1'b0;
  bit          m_pop, m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc  = RV;
      m_mis = 1'b0;
    end else if (bus.redirect_valid) begin
      mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
      m_mis = (bus.redirect_pc % 4) != 0;
`else
      m_pc  = bus.redirect_pc;
      m_mis = 1'b0;
`endif
    end else begin
      m_mis  = 1'b0;
      m_pop  = (mq.size() != 0) && bus.out_ready;
      m_push = (mq.size() < DEPTH) || m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    check("model_imem_addr", bus.imem_addr, m_pc);
    check("model_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    check("model_misalign", 32'(bus.misalign_err), 32'(m_mis));
    if (mq.size() != 0) begin
      check("model_out_pc", bus.out_pc, mq[0][63:32]);
      check("model_out_instr", bus.out_instruction, mq[0][31:0]);
    end
  end

  task automatic head(input string name, input logic [31:0] pc);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_pc"}, bus.out_pc, pc);
    check({name, "_instr"}, bus.out_instruction, mem_word(pc));
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_addr", bus.imem_addr, RV);
    check("rst_misalign", 32'(bus.misalign_err), 32'd0);

    // Streaming from reset
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      head("stream", RV + 32'(4 * i));
    end

    // Stall fills the queue and freezes the PC
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    head("stall_hold", 32'h0);
    check("stall_addr", bus.imem_addr, 32'h8);
    bus.out_ready = 1'b1;
    @(negedge clk);
    head("drain1", 32'h4);
    @(negedge clk);
    head("drain2", 32'h8);

    // Redirect while full
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    head("full_head", 32'h8);
    check("full_addr", bus.imem_addr, 32'h10);
    redirect(32'h40);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_addr", bus.imem_addr, 32'h40);
    bus.out_ready = 1'b1;
    @(negedge clk);
    head("redir_a", 32'h40);
    @(negedge clk);
    head("redir_b", 32'h44);

    // Redirect with out_ready high: nothing consumed or enqueued that cycle
    redirect(32'h100);
    check("rdy_flush_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    head("rdy_redir", 32'h100);

    // Back-to-back redirects: last one wins
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    @(negedge clk);
    redirect(32'h300);
    check("b2b_valid", 32'(bus.out_valid), 32'd0);
    check("b2b_addr", bus.imem_addr, 32'h300);
    @(negedge clk);
    head("b2b_head", 32'h300);

    // PC wrap
    redirect(32'hFFFF_FFF8);
    @(negedge clk);
    head("wrap0", 32'hFFFF_FFF8);
    @(negedge clk);
    head("wrap1", 32'hFFFF_FFFC);
    @(negedge clk);
    head("wrap2", 32'h0000_0000);

    // Misaligned redirect
    redirect(32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_flag", 32'(bus.misalign_err), 32'd1);
    check("mis_addr", bus.imem_addr, 32'h40);
    @(negedge clk);
    check("mis_flag_clr", 32'(bus.misalign_err), 32'd0);
    head("mis_head", 32'h40);
`else
    check("mis_flag", 32'(bus.misalign_err), 32'd0);
    check("mis_addr", bus.imem_addr, 32'h42);
    @(negedge clk);
    check("mis_flag_clr", 32'(bus.misalign_err), 32'd0);
    head("mis_head", 32'h42);
`endif

    // Async reset mid-stream with a partially filled queue
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.out_valid), 32'd0);
    check("async_addr", bus.imem_addr, RV);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    head("restart0", RV);
    @(negedge clk);
    head("restart1", RV + 32'h4);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
